// File: rtl/alu_seq_if.sv
// Handshaked operand/result bundle for alu_seq.
// The master drives operands and out_ready. The slave (the ALU) drives in_ready and the results.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ALU_control;
    logic [2:0]       bonus_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, src1, src2, ALU_control, bonus_control, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, cout, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, src1, src2, ALU_control, bonus_control, out_ready,
        output in_ready, out_valid, result, result_hi, zero, cout, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/compare/shift ops, plus iterative
// shift-add MULU and restoring DIVU that take WIDTH+1 edges from accept to result.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULU = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic             r_fin;
    logic             r_isdiv;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;
    logic             r_dbz;

    logic             w_accept;
    logic             w_multi;
    logic             w_sub;
    logic [WIDTH-1:0] w_beff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic             w_lt;
    logic             w_eq;
    logic             w_cmp;
    logic             w_cmp_ok;
    logic [WIDTH-1:0] w_res;
    logic             w_cout_o;
    logic             w_ovf_o;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_dt;
    logic [WIDTH:0]   w_dd;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    assign bus.in_ready = rst_n && ((r_state == IDLE) || (r_state == DONE && bus.out_ready));
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_multi      = (bus.ALU_control == OP_MULU) || (bus.ALU_control == OP_DIVU);

    // Compares reuse the subtractor: A + ~B + 1
    assign w_sub  = (bus.ALU_control == OP_SUB) || (bus.ALU_control == OP_SLT);
    assign w_beff = w_sub ? ~bus.src2 : bus.src2;
    assign w_sum  = {1'b0, bus.src1} + {1'b0, w_beff} + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf  = (bus.src1[WIDTH-1] ^ w_beff[WIDTH-1] ^ w_sum[WIDTH-1]) ^ w_sum[WIDTH];
    assign w_lt   = w_sum[WIDTH-1] ^ w_ovf;
    assign w_eq   = (bus.src1 == bus.src2);

    always_comb begin
        w_cmp    = 1'b0;
        w_cmp_ok = 1'b1;
        case (bus.bonus_control)
            3'b000:  w_cmp = w_lt;
            3'b001:  w_cmp = !w_lt && !w_eq;
            3'b010:  w_cmp = w_lt || w_eq;
            3'b011:  w_cmp = !w_lt;
            3'b100:  w_cmp = !w_eq;
            3'b110:  w_cmp = w_eq;
            default: w_cmp_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_res    = '0;
        w_cout_o = 1'b0;
        w_ovf_o  = 1'b0;
        case (bus.ALU_control)
            OP_AND:  w_res = bus.src1 & bus.src2;
            OP_OR:   w_res = bus.src1 | bus.src2;
            OP_NOR:  w_res = ~(bus.src1 | bus.src2);
            OP_NAND: w_res = ~(bus.src1 & bus.src2);
            OP_ADD, OP_SUB: begin
                w_res    = w_sum[WIDTH-1:0];
                w_cout_o = w_sum[WIDTH];
                w_ovf_o  = w_ovf;
            end
            OP_SLT:  if (w_cmp_ok) w_res = {{(WIDTH-1){1'b0}}, w_cmp};
            OP_SLL:  w_res = bus.src1 << bus.src2[SHW-1:0];
            OP_SRL:  w_res = bus.src1 >> bus.src2[SHW-1:0];
            default: w_res = '0;
        endcase
    end

    // One iteration: r_hi holds partial product / remainder, r_lo multiplier / quotient
    always_comb begin
        w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_dt   = {r_hi, r_lo[WIDTH-1]};
        w_dd   = w_dt - {1'b0, r_b};
        if (r_isdiv) begin
            if (!w_dd[WIDTH]) begin
                w_step_hi = w_dd[WIDTH-1:0];
                w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_dt[WIDTH-1:0];
                w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_madd[WIDTH:1];
            w_step_lo = {w_madd[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_fin       <= 1'b0;
            r_isdiv     <= 1'b0;
            r_b         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_multi) begin
                r_state     <= BUSY;
                r_cnt       <= CNT_INIT;
                r_fin       <= 1'b0;
                r_isdiv     <= (bus.ALU_control == OP_DIVU);
                r_b         <= bus.src2;
                r_hi        <= '0;
                r_lo        <= bus.src1;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= DONE;
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_result_hi <= '0;
                r_zero      <= (w_res == '0);
                r_cout      <= w_cout_o;
                r_ovf       <= w_ovf_o;
                r_dbz       <= 1'b0;
            end
        end else begin
            case (r_state)
                BUSY: begin
                    // The extra edge after the last step publishes the result
                    if (r_fin) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= r_lo;
                        r_result_hi <= r_hi;
                        r_zero      <= (r_lo == '0);
                        r_cout      <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_dbz       <= r_isdiv && (r_b == '0);
                    end else begin
                        r_hi  <= w_step_hi;
                        r_lo  <= w_step_lo;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) r_fin <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.result_hi   = r_result_hi;
    assign bus.zero        = r_zero;
    assign bus.cout        = r_cout;
    assign bus.overflow    = r_ovf;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32: directed vectors push expectations,
// a monitor pops and compares every consumed result.
module tb_alu_seq;
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        c;
        logic        v;
        logic        d;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    exp_t q[$];
    string nq[$];

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic [31:0] res, logic [31:0] hi, logic z, logic c, logic v, logic d);
        exp_t e;
        e.res = res; e.hi = hi; e.z = z; e.c = c; e.v = v; e.d = d;
        return e;
    endfunction

    function automatic exp_t cur();
        return mk(bus.result, bus.result_hi, bus.zero, bus.cout, bus.overflow, bus.div_by_zero);
    endfunction

    task automatic chk(string nm, logic [67:0] act, logic [67:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(string nm, logic [3:0] op, logic [2:0] bc, logic [31:0] a, logic [31:0] b, exp_t e);
        bus.in_valid      = 1'b1;
        bus.ALU_control   = op;
        bus.bonus_control = bc;
        bus.src1          = a;
        bus.src2          = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                q.push_back(e);
                nq.push_back(nm);
                bus.in_valid = 1'b0;
                bus.src1     = $urandom;
                bus.src2     = $urandom;
                return;
            end
        end
        bus.in_valid = 1'b0;
        chk({nm, "_accept_timeout"}, 68'd0, 68'd1);
    endtask

    task automatic wait_valid(output int lat, output bit rdy_seen);
        lat      = 0;
        rdy_seen = bus.in_ready;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            lat = k;
            if (bus.out_valid) break;
            if (bus.in_ready) rdy_seen = 1'b1;
        end
    endtask

    // Monitor: every consumed result must match the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", cur(), 68'd0);
                end else begin
                    exp_t  e;
                    string nm;
                    e  = q.pop_front();
                    nm = nq.pop_front();
                    chk(nm, cur(), e);
                end
            end
        end
    end

    initial begin
        int lat;
        bit rdy_seen;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b1;
        bus.src1          = '0;
        bus.src2          = '0;
        bus.ALU_control   = '0;
        bus.bonus_control = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_outputs", cur(), 68'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        issue("add_ovf", 4'b0010, 3'b000, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 0, 0, 0, 1, 0));
        issue("sub_zero", 4'b0110, 3'b000, 32'd5, 32'd5, mk(0, 0, 1, 1, 0, 0));
        issue("slt", 4'b0111, 3'b000, 32'hFFFF_FFFF, 32'd1, mk(1, 0, 0, 0, 0, 0));
        issue("sge", 4'b0111, 3'b011, 32'hFFFF_FFFF, 32'd1, mk(0, 0, 1, 0, 0, 0));
        issue("seq", 4'b0111, 3'b110, 32'h8000_0000, 32'h8000_0000, mk(1, 0, 0, 0, 0, 0));
        issue("sgt_ovf", 4'b0111, 3'b001, 32'h8000_0000, 32'h7FFF_FFFF, mk(0, 0, 1, 0, 0, 0));
        issue("sle_eq", 4'b0111, 3'b010, 32'd7, 32'd7, mk(1, 0, 0, 0, 0, 0));
        issue("sne", 4'b0111, 3'b100, 32'd7, 32'd7, mk(0, 0, 1, 0, 0, 0));
        issue("and", 4'b0000, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 0, 0, 0, 0, 0));
        issue("or", 4'b0001, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hFFF0_FFF0, 0, 0, 0, 0, 0));
        issue("nor", 4'b1100, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h000F_000F, 0, 0, 0, 0, 0));
        issue("nand", 4'b1101, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h0FFF_0FFF, 0, 0, 0, 0, 0));
        issue("sll", 4'b1000, 3'b000, 32'h1, 32'h0000_0024, mk(32'h10, 0, 0, 0, 0, 0));
        issue("srl", 4'b1001, 3'b000, 32'h8000_0000, 32'h0000_001F, mk(32'h1, 0, 0, 0, 0, 0));
        issue("bad_op", 4'b1111, 3'b000, 32'h1234, 32'h5678, mk(0, 0, 1, 0, 0, 0));
        issue("bad_cmp", 4'b0111, 3'b101, 32'hFFFF_FFFF, 32'd1, mk(0, 0, 1, 0, 0, 0));

        issue("mulu_max", 4'b0011, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'h1, 32'hFFFF_FFFE, 0, 0, 0, 0));
        wait_valid(lat, rdy_seen);
        chk("mulu_latency", lat, 33);
        chk("mulu_in_ready_low", rdy_seen, 0);
        issue("mulu_small", 4'b0011, 3'b000, 32'd3, 32'd5, mk(32'd15, 0, 0, 0, 0, 0));
        issue("divu", 4'b0100, 3'b000, 32'd100, 32'd7, mk(32'd14, 32'd2, 0, 0, 0, 0));
        issue("divu_zero", 4'b0100, 3'b000, 32'd9, 32'd0, mk(32'hFFFF_FFFF, 32'd9, 0, 0, 0, 1));
        wait_valid(lat, rdy_seen);
        chk("divz_latency", lat, 33);

        // Backpressure, then consume and accept on the same edge
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue("bp_add", 4'b0010, 3'b000, 32'd3, 32'd4, mk(32'd7, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {bus.out_valid, cur()}, {1'b1, mk(32'd7, 0, 0, 0, 0, 0)});
        end
        bus.out_ready = 1'b1;
        issue("bp_next", 4'b0010, 3'b000, 32'd10, 32'd20, mk(32'd30, 0, 0, 0, 0, 0));
        chk("bp_no_gap", {bus.out_valid, bus.result}, {1'b1, 32'd30});

        // Reset while a MULU is in flight
        issue("mulu_abort", 4'b0011, 3'b000, 32'h1234_5678, 32'd9, mk(0, 0, 0, 0, 0, 0));
        void'(q.pop_back());
        void'(nq.pop_back());
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_outputs", cur(), 68'd0);
        chk("abort_idle", bus.in_ready, 1);
        issue("divu_after", 4'b0100, 3'b000, 32'd1000, 32'd10, mk(32'd100, 32'd0, 0, 0, 0, 0));
        wait_valid(lat, rdy_seen);
        chk("after_latency", lat, 33);

        for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
